// File: rtl/traffic_pkg.sv
// Shared constants for the emergency command path (parser and traffic controller).
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: command byte codes, frame delimiters, checksum XOR mask, parser state
// enum and a legal-command helper. The CHK state encoding exists in every build
// but is only reachable when CMD_CHECKSUM_EN is defined.
package traffic_pkg;

  localparam logic [7:0] CMD_N    = 8'h4E;
  localparam logic [7:0] CMD_S    = 8'h53;
  localparam logic [7:0] CMD_E    = 8'h45;
  localparam logic [7:0] CMD_W    = 8'h57;
  localparam logic [7:0] CMD_C    = 8'h43;
  localparam logic [7:0] SOF_BYTE = 8'h24;
  localparam logic [7:0] EOF_BYTE = 8'h0A;
  localparam logic [7:0] CHK_XOR  = 8'h7F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOF  = 2'd1,
    ST_CMD  = 2'd2,
    ST_CHK  = 2'd3
  } parser_state_e;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_N) || (b == CMD_S) || (b == CMD_E) ||
           (b == CMD_W) || (b == CMD_C);
  endfunction

endpackage

// File: rtl/emergency_cmd_parser_watchdog.sv
// Hold-window watchdog: prescaler plus seconds down-counter for an active emergency.
// Latency: expire is combinational from state; arm/disarm take effect next cycle.
// Backpressure: defer freezes the counter on the expiry cycle so expiry slips by one clock.
// Ports: CLOCK_50/reset (sync, active-high); arm reloads and arms; disarm clears;
// defer postpones expiry while the parent is busy reporting a frame error;
// expire is a one-cycle expiry request; armed is high while the window is running.
module cmd_watchdog
  #(
    parameter int CLKS_PER_SEC = 50_000_000,
    parameter int HOLD_SECS    = 30
  )
  (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic arm,
    input  logic disarm,
    input  logic defer,
    output logic expire,
    output logic armed
  );

  localparam int PW = $clog2(CLKS_PER_SEC) + 1;

  logic [PW-1:0] presc;
  logic [7:0]    secs;
  logic          wrap;
  logic          last_sec;

  assign wrap     = (presc == PW'(CLKS_PER_SEC - 1));
  assign last_sec = (secs == 8'd1);
  assign expire   = armed && wrap && last_sec && !defer;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      armed <= 1'b0;
      presc <= '0;
      secs  <= '0;
    end else if (arm) begin
      armed <= 1'b1;
      presc <= '0;
      secs  <= 8'(HOLD_SECS);
    end else if (disarm) begin
      armed <= 1'b0;
      presc <= '0;
      secs  <= '0;
    end else if (armed && !(wrap && last_sec && defer)) begin
      if (wrap) begin
        presc <= '0;
        secs  <= secs - 8'd1;
        if (last_sec) armed <= 1'b0;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/emergency_cmd_parser.sv
// Parses '$' CMD LF emergency frames from uart_rx bytes into a validated command strobe.
// Latency: cmd_valid/frame_err one cycle after the terminating/offending rx_done.
// Backpressure: none; the controller must consume every one-cycle strobe.
// Ports: CLOCK_50, reset (sync, active-high), rx_data/rx_done from uart_rx;
// cmd_code/cmd_valid validated command, frame_err/err_count rejects (saturating),
// wd_active while an emergency is held. Optional macro CMD_CHECKSUM_EN adds a
// CHK byte (CMD ^ 0x7F) between CMD and LF.
module emergency_cmd_parser
  import traffic_pkg::*;
  #(
    parameter int CLKS_PER_BIT = 434,
    parameter int GAP_BITS     = 20,
    parameter int CLKS_PER_SEC = 50_000_000,
    parameter int HOLD_SECS    = 30
  )
  (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] cmd_code,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic [7:0] err_count,
    output logic       wd_active
  );

  localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
  localparam int GW        = $clog2(GAP_LIMIT) + 1;

  parser_state_e state, state_nxt;
  logic [7:0]    cmd_lat, cmd_lat_nxt;
  logic [GW-1:0] gap_cnt;
  logic          accept, byte_err, gap_to, ferr_evt;
  logic          wd_expire;

  always_comb begin
    state_nxt   = state;
    cmd_lat_nxt = cmd_lat;
    accept      = 1'b0;
    byte_err    = 1'b0;
    if (rx_done) begin
      case (state)
        ST_IDLE: if (rx_data == SOF_BYTE) state_nxt = ST_SOF;
        ST_SOF: begin
          // A repeated '$' is a harmless resync, not an error.
          if (rx_data == SOF_BYTE) begin
            state_nxt = ST_SOF;
          end else if (is_cmd(rx_data)) begin
            cmd_lat_nxt = rx_data;
            state_nxt   = ST_CMD;
          end else begin
            byte_err  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_CMD: begin
          if (rx_data == SOF_BYTE) begin
            byte_err  = 1'b1;
            state_nxt = ST_SOF;
`ifdef CMD_CHECKSUM_EN
          end else if (rx_data == (cmd_lat ^ CHK_XOR)) begin
            state_nxt = ST_CHK;
`else
          end else if (rx_data == EOF_BYTE) begin
            accept    = 1'b1;
            state_nxt = ST_IDLE;
`endif
          end else begin
            byte_err  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
`ifdef CMD_CHECKSUM_EN
        ST_CHK: begin
          if (rx_data == SOF_BYTE) begin
            byte_err  = 1'b1;
            state_nxt = ST_SOF;
          end else if (rx_data == EOF_BYTE) begin
            accept    = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            byte_err  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
`endif
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // A byte arriving on the timeout cycle is processed; the timeout is dropped.
  assign gap_to   = (state != ST_IDLE) && !rx_done && (gap_cnt == GW'(GAP_LIMIT - 1));
  assign ferr_evt = byte_err || gap_to;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd_lat   <= CMD_C;
      gap_cnt   <= '0;
      cmd_code  <= CMD_C;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= gap_to ? ST_IDLE : state_nxt;
      cmd_lat   <= cmd_lat_nxt;
      frame_err <= ferr_evt;
      cmd_valid <= 1'b0;
      if (rx_done || gap_to || state_nxt == ST_IDLE) gap_cnt <= '0;
      else                                           gap_cnt <= gap_cnt + GW'(1);
      // A frame accepted on the expiry cycle wins; only one strobe results.
      if (accept) begin
        cmd_code  <= cmd_lat;
        cmd_valid <= 1'b1;
      end else if (wd_expire) begin
        cmd_code  <= CMD_C;
        cmd_valid <= 1'b1;
      end
      if (ferr_evt && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  // Expiry is deferred while frame_err fires so the two strobes never overlap.
  cmd_watchdog #(
    .CLKS_PER_SEC(CLKS_PER_SEC),
    .HOLD_SECS   (HOLD_SECS)
  ) u_watchdog (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .arm     (accept && cmd_lat != CMD_C),
    .disarm  (accept && cmd_lat == CMD_C),
    .defer   (ferr_evt),
    .expire  (wd_expire),
    .armed   (wd_active)
  );

endmodule

// File: tb/tb_emergency_cmd_parser.sv
// Self-checking bench for emergency_cmd_parser with a queue-based frame model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a; the bench drives one byte or idle per clock.
module tb_emergency_cmd_parser;

  localparam int CPB  = 4;
  localparam int GAPB = 10;
  localparam int CPS  = 10;
  localparam int HOLD = 2;
  localparam int GAP_LIM = CPB * GAPB;
`ifdef CMD_CHECKSUM_EN
  localparam int FB = 4;
`else
  localparam int FB = 3;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_done  = 1'b0;
  logic [7:0] cmd_code;
  logic       cmd_valid;
  logic       frame_err;
  logic [7:0] err_count;
  logic       wd_active;

  emergency_cmd_parser #(
    .CLKS_PER_BIT(CPB), .GAP_BITS(GAPB), .CLKS_PER_SEC(CPS), .HOLD_SECS(HOLD)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .cmd_code (cmd_code),
    .cmd_valid(cmd_valid),
    .frame_err(frame_err),
    .err_count(err_count),
    .wd_active(wd_active)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  // Reference model: partial frame as a byte queue, watchdog as an absolute deadline.
  logic [7:0] q[$];
  int         cyc = 0;
  int         last_rx = 0;
  int         deadline = 0;
  logic [7:0] e_code = 8'h43;
  logic [7:0] e_cnt = 8'h00;
  logic       e_valid = 1'b0;
  logic       e_ferr = 1'b0;
  logic       e_wd = 1'b0;

  task automatic model_cycle(input logic dv, input logic [7:0] b);
    logic       acc;
    logic       err;
    logic [7:0] accb;
    acc = 1'b0; err = 1'b0; accb = 8'h00;
    e_valid = 1'b0; e_ferr = 1'b0;
    if (reset) begin
      q.delete(); e_code = 8'h43; e_cnt = 8'h00; e_wd = 1'b0;
      return;
    end
    if (dv) begin
      last_rx = cyc;
      if (q.size() == 0) begin
        if (b == 8'h24) q.push_back(b);
      end else if (b == 8'h24) begin
        if (q.size() > 1) err = 1'b1;
        q.delete(); q.push_back(b);
      end else if (q.size() == 1) begin
        if (b inside {8'h4E, 8'h53, 8'h45, 8'h57, 8'h43}) q.push_back(b);
        else begin err = 1'b1; q.delete(); end
      end else if (q.size() == FB - 1) begin
        if (b == 8'h0A) begin acc = 1'b1; accb = q[1]; end
        else err = 1'b1;
        q.delete();
      end else begin
        if (b == (q[1] ^ 8'h7F)) q.push_back(b);
        else begin err = 1'b1; q.delete(); end
      end
    end else if (q.size() > 0 && cyc - last_rx == GAP_LIM) begin
      err = 1'b1; q.delete();
    end
    if (acc) begin
      e_valid = 1'b1; e_code = accb;
      if (accb == 8'h43) e_wd = 1'b0;
      else begin e_wd = 1'b1; deadline = cyc + HOLD * CPS; end
    end else if (e_wd && cyc == deadline) begin
      if (err) deadline = deadline + 1;
      else begin e_code = 8'h43; e_valid = 1'b1; e_wd = 1'b0; end
    end
    if (err) begin
      e_ferr = 1'b1;
      if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
    end
  endtask

  task automatic tick(input logic dv, input logic [7:0] b);
    rx_done = dv; rx_data = b;
    model_cycle(dv, b);
    @(posedge CLOCK_50); #1;
    rx_done = 1'b0;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic send_tail(input logic [7:0] c);
    tick(1'b1, c);
`ifdef CMD_CHECKSUM_EN
    tick(1'b1, c ^ 8'h7F);
`endif
    tick(1'b1, 8'h0A);
  endtask

  task automatic send_frame(input logic [7:0] c);
    tick(1'b1, 8'h24);
    send_tail(c);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(2);
    checks++; if (cmd_code !== 8'h43) begin errors++; $display("FAIL reset_code got %h want 43", cmd_code); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", cmd_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_cnt got %h want 00", err_count); end
    checks++; if (wd_active !== 1'b0) begin errors++; $display("FAIL reset_wd got %b want 0", wd_active); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_accept;
    send_frame(8'h4E);
    checks++; if (cmd_code !== 8'h4E) begin errors++; $display("FAIL accept_code got %h want 4e", cmd_code); end
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL accept_valid got %b want 1", cmd_valid); end
    checks++; if (wd_active !== 1'b1) begin errors++; $display("FAIL accept_wd got %b want 1", wd_active); end
    idle(1);
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL accept_pulse got %b want 0", cmd_valid); end
    send_frame(8'h43);
    checks++; if (cmd_code !== 8'h43 || wd_active !== 1'b0) begin errors++; $display("FAIL clear_cmd got %h/%b want 43/0", cmd_code, wd_active); end
  endtask

  task automatic test_bad_cmd;
    tick(1'b1, 8'h24);
    tick(1'b1, 8'h58);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL badcmd_ferr got %b want 1", frame_err); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL badcmd_cnt got %0d want 1", err_count); end
    checks++; if (cmd_code !== 8'h43 || cmd_valid !== 1'b0) begin errors++; $display("FAIL badcmd_code got %h/%b want 43/0", cmd_code, cmd_valid); end
    tick(1'b1, 8'h0A);
    checks++; if (frame_err !== 1'b0 || err_count !== 8'd1) begin errors++; $display("FAIL idle_lf got %b/%0d want 0/1", frame_err, err_count); end
  endtask

  task automatic test_resync;
    tick(1'b1, 8'h24);
    tick(1'b1, 8'h53);
    tick(1'b1, 8'h24);
    checks++; if (frame_err !== 1'b1 || err_count !== 8'd2) begin errors++; $display("FAIL resync_ferr got %b/%0d want 1/2", frame_err, err_count); end
    send_tail(8'h45);
    checks++; if (cmd_code !== 8'h45 || cmd_valid !== 1'b1) begin errors++; $display("FAIL resync_acc got %h/%b want 45/1", cmd_code, cmd_valid); end
    send_frame(8'h43);
  endtask

  task automatic test_watchdog;
    send_frame(8'h57);
    idle(19);
    checks++; if (cmd_code !== 8'h57 || wd_active !== 1'b1) begin errors++; $display("FAIL wd_early got %h/%b want 57/1", cmd_code, wd_active); end
    idle(1);
    checks++; if (cmd_code !== 8'h43 || cmd_valid !== 1'b1 || wd_active !== 1'b0) begin errors++; $display("FAIL wd_expire got %h/%b/%b want 43/1/0", cmd_code, cmd_valid, wd_active); end
    idle(1);
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL wd_once got %b want 0", cmd_valid); end
  endtask

  task automatic test_refresh;
    send_frame(8'h57);
    idle(15 - FB);
    send_frame(8'h57);
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL keepalive got %b want 1", cmd_valid); end
    idle(19);
    checks++; if (cmd_code !== 8'h57 || wd_active !== 1'b1) begin errors++; $display("FAIL refresh_hold got %h/%b want 57/1", cmd_code, wd_active); end
    idle(1);
    checks++; if (cmd_code !== 8'h43 || cmd_valid !== 1'b1) begin errors++; $display("FAIL refresh_exp got %h/%b want 43/1", cmd_code, cmd_valid); end
  endtask

  task automatic test_gap;
    tick(1'b1, 8'h24);
    idle(GAP_LIM - 1);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL gap_early got %b want 0", frame_err); end
    idle(1);
    checks++; if (frame_err !== 1'b1 || err_count !== 8'd3) begin errors++; $display("FAIL gap_to got %b/%0d want 1/3", frame_err, err_count); end
    send_tail(8'h4E);
    checks++; if (cmd_valid !== 1'b0 || cmd_code !== 8'h43 || frame_err !== 1'b0) begin errors++; $display("FAIL gap_idle got %b/%h/%b want 0/43/0", cmd_valid, cmd_code, frame_err); end
    // A byte on the timeout cycle itself keeps the frame alive.
    tick(1'b1, 8'h24);
    idle(GAP_LIM - 1);
    tick(1'b1, 8'h4E);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL gap_edge got %b want 0", frame_err); end
`ifdef CMD_CHECKSUM_EN
    tick(1'b1, 8'h31);
`endif
    tick(1'b1, 8'h0A);
    checks++; if (cmd_code !== 8'h4E || cmd_valid !== 1'b1) begin errors++; $display("FAIL gap_edge_acc got %h/%b want 4e/1", cmd_code, cmd_valid); end
    send_frame(8'h43);
  endtask

`ifdef CMD_CHECKSUM_EN
  task automatic test_checksum;
    tick(1'b1, 8'h24); tick(1'b1, 8'h4E); tick(1'b1, 8'h31); tick(1'b1, 8'h0A);
    checks++; if (cmd_code !== 8'h4E || cmd_valid !== 1'b1) begin errors++; $display("FAIL chk_ok got %h/%b want 4e/1", cmd_code, cmd_valid); end
    tick(1'b1, 8'h24); tick(1'b1, 8'h4E); tick(1'b1, 8'h30);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL chk_bad got %b want 1", frame_err); end
    tick(1'b1, 8'h0A);
    checks++; if (cmd_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL chk_lf got %b/%b want 0/0", cmd_valid, frame_err); end
    send_frame(8'h43);
  endtask
`endif

  task automatic test_random;
    logic [7:0] cmds [5];
    logic [7:0] pend[$];
    logic [7:0] c;
    int quiet;
    cmds = '{8'h4E, 8'h53, 8'h45, 8'h57, 8'h43};
    quiet = 0;
    for (int i = 0; i < 4000; i++) begin
      if (pend.size() == 0) begin
        c = cmds[$urandom_range(0, 4)];
        pend.push_back(8'h24);
        pend.push_back(c);
`ifdef CMD_CHECKSUM_EN
        pend.push_back(c ^ 8'h7F);
`endif
        pend.push_back(8'h0A);
        if ($urandom_range(0, 3) == 0) pend[$urandom_range(0, FB - 1)] = 8'($urandom_range(0, 255));
      end
      if (quiet == 0 && $urandom_range(0, 40) == 0) quiet = $urandom_range(10, 45);
      if (quiet > 0) begin
        quiet--;
        tick(1'b0, 8'h00);
      end else if ($urandom_range(0, 2) == 0) begin
        tick(1'b0, 8'h00);
      end else begin
        tick(1'b1, pend.pop_front());
      end
      checks++; if (cmd_code !== e_code) begin errors++; $display("FAIL rnd_code cyc %0d got %h want %h", cyc, cmd_code, e_code); end
      checks++; if (cmd_valid !== e_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, cmd_valid, e_valid); end
      checks++; if (frame_err !== e_ferr) begin errors++; $display("FAIL rnd_ferr cyc %0d got %b want %b", cyc, frame_err, e_ferr); end
      checks++; if (err_count !== e_cnt) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", cyc, err_count, e_cnt); end
      checks++; if (wd_active !== e_wd) begin errors++; $display("FAIL rnd_wd cyc %0d got %b want %b", cyc, wd_active, e_wd); end
      checks++; if (cmd_valid === 1'b1 && frame_err === 1'b1) begin errors++; $display("FAIL rnd_excl cyc %0d got both high want exclusive", cyc); end
    end
  endtask

  task automatic test_err_saturate;
    for (int i = 0; i < 260; i++) begin
      tick(1'b1, 8'h24);
      tick(1'b1, 8'h58);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL sat_ferr iter %0d got %b want 1", i, frame_err); end
    end
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL sat_cnt got %0d want 255", err_count); end
  endtask

  task automatic test_reset_midframe;
    send_frame(8'h57);
    tick(1'b1, 8'h24);
    tick(1'b1, 8'h4E);
    reset = 1'b1;
    tick(1'b1, 8'h0A);
    checks++; if (cmd_code !== 8'h43 || cmd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_code got %h/%b want 43/0", cmd_code, cmd_valid); end
    checks++; if (frame_err !== 1'b0 || err_count !== 8'h00) begin errors++; $display("FAIL rstmid_err got %b/%0d want 0/0", frame_err, err_count); end
    checks++; if (wd_active !== 1'b0) begin errors++; $display("FAIL rstmid_wd got %b want 0", wd_active); end
    reset = 1'b0;
    tick(1'b1, 8'h0A);
    checks++; if (cmd_valid !== 1'b0 || frame_err !== 1'b0 || cmd_code !== 8'h43) begin errors++; $display("FAIL rstmid_after got %b/%b/%h want 0/0/43", cmd_valid, frame_err, cmd_code); end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_bad_cmd();
    test_resync();
    test_watchdog();
    test_refresh();
    test_gap();
`ifdef CMD_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    test_err_saturate();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL time_limit got no finish want finish");
    $fatal(1, "time limit");
  end

endmodule
